// File: rtl/codec_sample_source.sv
// codec_sample_source
//   Master-mode I2S receive front end. Generates SCLK/LRCLK for the codec,
//   deserializes SDOUT into left/right words and strobes wrt_smpl once per
//   stereo frame so the sample circular buffers can take the new pair.

module codec_sample_source #(
  parameter int SCLK_DIV = 32,  // clk cycles per SCLK period, even and >= 8
  parameter int SMPL_W   = 16   // bits per channel word
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sdout,
  output logic              sclk,
  output logic              lrclk,
  output logic [SMPL_W-1:0] lft_smpl,
  output logic [SMPL_W-1:0] rht_smpl,
  output logic              wrt_smpl
);

  localparam int FRAME_W = 2 * SMPL_W;
  localparam int CNT_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [CNT_W-1:0] RISE_CNT = CNT_W'(SCLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FALL_CNT = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(SCLK_DIV / 2);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] LR_BIT   = BIT_W'(SMPL_W);

  typedef enum logic [0:0] {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [CNT_W-1:0]     sclk_cnt;
  logic [CNT_W-1:0]     sclk_cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_cnt_nxt;
  logic                 sdout_s1;
  logic                 sdout_s2;
  logic [FRAME_W-1:0]   shift_reg;
  logic [FRAME_W-1:0]   shift_nxt;
  logic                 started;
  logic                 rise_evt;
  logic                 fall_evt;
  logic                 frame_done;
  logic                 strobe_nxt;
  logic                 stopped;

  assign stopped  = rst | ~en;
  assign rise_evt = (sclk_cnt == RISE_CNT);
  assign fall_evt = (sclk_cnt == FALL_CNT);

  // The bit_cnt==0 rise at the very start of a run precedes any frame, so a
  // completion is only recognised once at least one SCLK fall has occurred.
  assign frame_done = rise_evt && (bit_cnt == '0) && started;

  // Next-state values for the bit clock counters and the capture shifter.
  always_comb begin
    sclk_cnt_nxt = sclk_cnt + 1'b1;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_reg;
    if (fall_evt) begin
      sclk_cnt_nxt = '0;
      if (bit_cnt == LAST_BIT) begin
        bit_cnt_nxt = '0;
      end else begin
        bit_cnt_nxt = bit_cnt + 1'b1;
      end
    end
    if (rise_evt) begin
      shift_nxt = {shift_reg[FRAME_W-2:0], sdout_s2};
    end
  end

  // FSM state register; stop or reset always returns to warm-up.
  always_ff @(posedge clk) begin
    if (stopped) begin
      state <= WARMUP;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and strobe request: the first completion only arms RUN.
  always_comb begin
    state_nxt  = state;
    strobe_nxt = 1'b0;
    if (frame_done) begin
      case (state)
        WARMUP:  state_nxt = RUN;
        RUN:     strobe_nxt = 1'b1;
        default: state_nxt = WARMUP;
      endcase
    end
  end

  // Bit clock generation, input synchronisation and serial capture.
  always_ff @(posedge clk) begin
    if (stopped) begin
      sclk_cnt  <= '0;
      bit_cnt   <= '0;
      sclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdout_s1  <= 1'b0;
      sdout_s2  <= 1'b0;
      shift_reg <= '0;
      started   <= 1'b0;
      wrt_smpl  <= 1'b0;
    end else begin
      sclk_cnt  <= sclk_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      // Registered from the next count so sclk/lrclk track the counters
      // without an extra cycle of skew.
      sclk      <= (sclk_cnt_nxt >= HALF_CNT);
      lrclk     <= (bit_cnt_nxt >= LR_BIT);
      sdout_s1  <= sdout;
      sdout_s2  <= sdout_s1;
      shift_reg <= shift_nxt;
      started   <= started | fall_evt;
      wrt_smpl  <= strobe_nxt;
    end
  end

  // Sample output registers; they survive en=0 and only clear on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_smpl <= '0;
      rht_smpl <= '0;
    end else if (en && strobe_nxt) begin
      lft_smpl <= shift_nxt[FRAME_W-1:SMPL_W];
      rht_smpl <= shift_nxt[SMPL_W-1:0];
    end
  end

endmodule

// File: tb/tb_codec_sample_source.sv
// tb_codec_sample_source
//   Directed bench: two instances (default and SCLK_DIV=8), each fed by a
//   behavioural I2S codec that launches bits on falling sclk.

module tb_codec_sample_source;

  logic        clk = 1'b0;
  logic        rst_a, en_a, sdout_a;
  logic        sclk_a, lrclk_a, wrt_a;
  logic [15:0] lft_a, rht_a;
  logic        rst_b, en_b, sdout_b;
  logic        sclk_b, lrclk_b, wrt_b;
  logic [15:0] lft_b, rht_b;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // codec model state
  logic [15:0] cur_l_a, cur_r_a, nxt_l_a, nxt_r_a;
  logic [15:0] cur_l_b, cur_r_b;
  logic        prev_sclk_a = 1'b0, prev_lr_a = 1'b0;
  logic        prev_sclk_b = 1'b0, prev_lr_b = 1'b0;
  int          k_a = 0, k_b = 0;
  logic        tog_b = 1'b0;

  codec_sample_source dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .sdout(sdout_a),
    .sclk(sclk_a), .lrclk(lrclk_a), .lft_smpl(lft_a), .rht_smpl(rht_a),
    .wrt_smpl(wrt_a)
  );

  codec_sample_source #(.SCLK_DIV(8), .SMPL_W(16)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .sdout(sdout_b),
    .sclk(sclk_b), .lrclk(lrclk_b), .lft_smpl(lft_b), .rht_smpl(rht_b),
    .wrt_smpl(wrt_b)
  );

  always #5 clk = ~clk;

  // k = SCLK periods since the last lrclk edge; k=0 carries the other word's LSB
  function automatic logic codec_bit(input logic lr, input int k,
                                     input logic [15:0] l, input logic [15:0] r);
    if (k == 0) return lr ? l[0] : r[0];
    if (k > 16) return 1'b0;
    return lr ? r[16-k] : l[16-k];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_sclk_a && !sclk_a) begin
      if (lrclk_a != prev_lr_a) begin
        k_a = 0;
        if (!lrclk_a) cur_l_a = nxt_l_a;
        else          cur_r_a = nxt_r_a;
      end else begin
        k_a++;
      end
      prev_lr_a = lrclk_a;
      sdout_a = codec_bit(lrclk_a, k_a, cur_l_a, cur_r_a);
    end
    prev_sclk_a = sclk_a;
    if (prev_sclk_b && !sclk_b) begin
      if (lrclk_b != prev_lr_b) k_b = 0;
      else                      k_b++;
      prev_lr_b = lrclk_b;
      sdout_b = codec_bit(lrclk_b, k_b, cur_l_b, cur_r_b);
    end
    prev_sclk_b = sclk_b;
    // flip sdout one clk before each rise; the synced level must still win
    if (tog_b && (cyc % 8 == 2)) sdout_b = ~sdout_b;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk_strobe_a(input int t, input logic [15:0] l, input logic [15:0] r);
    run_to(t - 1); chk("a_wrt_pre", 32'(wrt_a), 32'd0);
    run_to(t);     chk("a_wrt", 32'(wrt_a), 32'd1);
    chk("a_lft", 32'(lft_a), 32'(l));
    chk("a_rht", 32'(rht_a), 32'(r));
    run_to(t + 1); chk("a_wrt_post", 32'(wrt_a), 32'd0);
  endtask

  task automatic chk_strobe_b(input int t);
    run_to(t - 1); chk("b_wrt_pre", 32'(wrt_b), 32'd0);
    run_to(t);     chk("b_wrt", 32'(wrt_b), 32'd1);
    chk("b_lft", 32'(lft_b), 32'h0000C0DE);
    chk("b_rht", 32'(rht_b), 32'h0000BEEF);
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b1; sdout_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b1; sdout_b = 1'b0;
    cur_l_a = 16'hA5C3; cur_r_a = 16'h1234;
    nxt_l_a = 16'hA5C3; nxt_r_a = 16'h1234;
    cur_l_b = 16'hC0DE; cur_r_b = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    cyc = 0;

    // reset state
    chk("rst_sclk",  32'(sclk_a),  32'd0);
    chk("rst_lrclk", 32'(lrclk_a), 32'd0);
    chk("rst_lft",   32'(lft_a),   32'd0);
    chk("rst_rht",   32'(rht_a),   32'd0);
    chk("rst_wrt",   32'(wrt_a),   32'd0);
    chk("rst_b_wrt", 32'(wrt_b),   32'd0);

    // bit clock and word select timing
    run_to(15);  chk("sclk_15",  32'(sclk_a), 32'd0);
    run_to(16);  chk("sclk_16",  32'(sclk_a), 32'd1);
    run_to(31);  chk("sclk_31",  32'(sclk_a), 32'd1);
    run_to(32);  chk("sclk_32",  32'(sclk_a), 32'd0);
    run_to(511); chk("lrclk_511", 32'(lrclk_a), 32'd0);
    run_to(512); chk("lrclk_512", 32'(lrclk_a), 32'd1);

    // SCLK_DIV=8 instance: 256-clk frames, first strobe at 516
    chk_strobe_b(516);
    run_to(517); chk("b_wrt_post", 32'(wrt_b), 32'd0);
    chk_strobe_b(772);
    run_to(1000);
    tog_b = 1'b1;

    run_to(1024); chk("lrclk_1024", 32'(lrclk_a), 32'd0);
    run_to(1040); chk("warmup_discard", 32'(wrt_a), 32'd0);

    // sync-latency capture on the fast instance
    chk_strobe_b(1540);
    run_to(1541); chk("b_wrt_post", 32'(wrt_b), 32'd0);
    chk_strobe_b(1796);

    // first real frame and the next
    chk_strobe_a(2064, 16'hA5C3, 16'h1234);
    chk_strobe_a(3088, 16'hA5C3, 16'h1234);

    // one-cycle reset mid-left word
    run_to(3500);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("mid_rst_sclk",  32'(sclk_a),  32'd0);
    chk("mid_rst_lrclk", 32'(lrclk_a), 32'd0);
    chk("mid_rst_lft",   32'(lft_a),   32'd0);
    chk("mid_rst_rht",   32'(rht_a),   32'd0);
    run_to(4112); chk("no_strobe_4112", 32'(wrt_a), 32'd0);
    run_to(4528); chk("no_strobe_4528", 32'(wrt_a), 32'd0);
    chk_strobe_a(5565, 16'hA5C3, 16'h1234);

    // boundary data words, raw bits
    nxt_l_a = 16'h8000; nxt_r_a = 16'h7FFF;
    chk_strobe_a(7613, 16'h8000, 16'h7FFF);
    nxt_l_a = 16'h0001; nxt_r_a = 16'hFFFF;
    chk_strobe_a(9661, 16'h0001, 16'hFFFF);
    nxt_l_a = 16'h1111; nxt_r_a = 16'h2222;
    chk_strobe_a(11709, 16'h1111, 16'h2222);

    // en low for 100 cycles while in RUN
    run_to(11800);
    en_a = 1'b0;
    run_to(11850);
    chk("en0_sclk",  32'(sclk_a),  32'd0);
    chk("en0_lrclk", 32'(lrclk_a), 32'd0);
    chk("en0_lft",   32'(lft_a),   32'h00001111);
    chk("en0_rht",   32'(rht_a),   32'h00002222);
    chk("en0_wrt",   32'(wrt_a),   32'd0);
    run_to(11900);
    en_a = 1'b1;
    run_to(12733); chk("en_no_strobe", 32'(wrt_a), 32'd0);
    chk_strobe_b(13828);
    chk_strobe_a(13964, 16'h1111, 16'h2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
